// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude arithmetic blocks: FSM state
// encoding and the field layout of the {sign, carry, magnitude} result word.
package sm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sm_state_t;

    // Result layout for a magnitude of mag_w bits: sign on top, carry-out
    // just below it, magnitude in [mag_w-1:0].
    function automatic int sm_sign_idx(input int mag_w);
        return mag_w + 1;
    endfunction

    function automatic int sm_carry_idx(input int mag_w);
        return mag_w;
    endfunction

    function automatic int sm_mag_msb(input int mag_w);
        return mag_w - 1;
    endfunction

endpackage

// File: rtl/sm_serial_fa.sv
// Single-bit serial full adder / subtractor with a registered carry (add mode)
// or borrow (subtract mode); mode = 1 selects x - y.
module sm_serial_fa (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic mode,
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    logic c_d;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        s = x ^ y ^ c;
        if (mode) begin
            c_d = (~x & y) | (~(x ^ y) & c);
        end else begin
            c_d = (x & y) | (c & (x ^ y));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= 1'b0;
        end else if (clr) begin
            c <= 1'b0;
        end else if (en) begin
            c <= c_d;
        end
    end

endmodule

// File: rtl/sm_serial_subtractor.sv
// Bit-serial sign-magnitude subtractor (a - b), LSB first, valid/ready on both
// sides. Defining SM_SUB_ADD_MODE_EN adds the op port (1 = a + b).
module sm_serial_subtractor
    import sm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SM_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int MAG_W     = WIDTH - 1;
    localparam int CNT_W     = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam int SIGN_IDX  = sm_sign_idx(MAG_W);
    localparam int CARRY_IDX = sm_carry_idx(MAG_W);
    localparam int MAG_MSB   = sm_mag_msb(MAG_W);

    sm_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [MAG_W-1:0] big_q, small_q, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q, sub_q;
    logic             fa_s, fa_c;

    logic             sa, sb_eff, same_sign, a_ge, res_zero;
    logic [MAG_W-1:0] ma, mb;

`ifdef SM_SUB_ADD_MODE_EN
    logic op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            op_q <= op;
        end
    end

    assign sb_eff = op_q ? b_q[WIDTH-1] : ~b_q[WIDTH-1];
`else
    assign sb_eff = ~b_q[WIDTH-1];
`endif

    // Operand analysis, used only in the LOAD cycle.
    always_comb begin
        sa        = a_q[WIDTH-1];
        ma        = a_q[MAG_W-1:0];
        mb        = b_q[MAG_W-1:0];
        same_sign = (sa == sb_eff);
        a_ge      = (ma >= mb);
        // A zero result is always reported as +0.
        res_zero  = same_sign ? ((ma == '0) && (mb == '0)) : (ma == mb);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(MAG_W - 1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            big_q   <= '0;
            small_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                LOAD: begin
                    // Larger magnitude always goes on the minuend side.
                    big_q   <= a_ge ? ma : mb;
                    small_q <= a_ge ? mb : ma;
                    sub_q   <= ~same_sign;
                    sign_q  <= res_zero ? 1'b0 : ((same_sign || a_ge) ? sa : sb_eff);
                    cnt_q   <= '0;
                end
                SHIFT: begin
                    big_q   <= big_q >> 1;
                    small_q <= small_q >> 1;
                    res_q   <= {fa_s, res_q[MAG_W-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    sm_serial_fa u_fa (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == LOAD),
        .en   (state_q == SHIFT),
        .mode (sub_q),
        .x    (big_q[0]),
        .y    (small_q[0]),
        .s    (fa_s),
        .c    (fa_c)
    );

    // The final borrow is always 0 because the smaller magnitude is subtracted.
    always_comb begin
        diff               = '0;
        diff[SIGN_IDX]     = sign_q;
        diff[CARRY_IDX]    = fa_c & ~sub_q;
        diff[MAG_MSB:0]    = res_q;
    end

endmodule

// File: tb/tb_sm_serial_subtractor.sv
// Directed self-checking bench for sm_serial_subtractor (default build, a - b).
module tb_sm_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int MAG_W = WIDTH - 1;
    // Accept cycle is cycle 0; out_valid appears in cycle MAG_W+2, i.e.
    // MAG_W+1 rising edges after the accepting edge.
    localparam int LAT_EDGES = MAG_W + 1;
    localparam int TIMEOUT   = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
    );

    // Presents one operand pair, waits for acceptance and then for out_valid.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          output int lat);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        lat      = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 9'h000) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h, expected 1 0 000",
                     in_ready, out_valid, diff);
        end
    endtask

    task automatic test_arith();
        logic [7:0] va [8];
        logic [7:0] vb [8];
        logic [8:0] ve [8];
        int lat;
        va = '{8'h05, 8'h03, 8'h85, 8'h7F, 8'h85, 8'h00, 8'h80, 8'hFF};
        vb = '{8'h03, 8'h05, 8'h05, 8'hFF, 8'h85, 8'h80, 8'h00, 8'h7F};
        ve = '{9'h002, 9'h102, 9'h10A, 9'h0FE, 9'h000, 9'h000, 9'h000, 9'h1FE};
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], lat);
            checks++;
            if (lat !== LAT_EDGES) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d edges, expected %0d", i, lat, LAT_EDGES);
            end
            checks++;
            if (diff !== ve[i]) begin
                errors++;
                $display("FAIL diff[%0d] a=%h b=%h: got %h, expected %h", i, va[i], vb[i], diff, ve[i]);
            end
            consume();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL release[%0d]: in_ready=%b out_valid=%b, expected 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(8'h05, 8'h03, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'h7F;
            b        = 8'h7F;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || diff !== 9'h002 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%b diff=%h in_ready=%b, expected 1 002 0",
                         k, out_valid, diff, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_valid: in_ready=%b out_valid=%b, expected 1 0 (idle)",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        @(negedge clk);
        a        = 8'h7F;
        b        = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // LOAD, then SHIFT bits 0..3
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 9'h000) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%h, expected 1 0 000",
                     in_ready, out_valid, diff);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_pulse: out_valid seen=%b after reset, expected 0", seen);
        end
        run_op(8'h10, 8'h01, lat);
        checks++;
        if (lat !== LAT_EDGES || diff !== 9'h00F) begin
            errors++;
            $display("FAIL after_reset: lat=%0d diff=%h, expected %0d 00F", lat, diff, LAT_EDGES);
        end
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_arith();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
